// File: rtl/aurora_link_pkg.sv
// ---------------------------------------------------------------------------
// aurora_link_pkg
// Shared definitions for the Aurora <-> CONNECT split-network link. The RX
// unpacker uses it today and the TX packer will use the same encodings.
//   - 16-bit word type codes carried in word[15:14]
//   - bit slices of head, tail and credit words
//   - RX framing FSM state encoding
// ---------------------------------------------------------------------------
package aurora_link_pkg;

    typedef logic [1:0] wordType_t;

    // Word type codes in word[15:14]
    localparam wordType_t WORD_HEAD = 2'b10;
    localparam wordType_t WORD_TAIL = 2'b01;
    localparam wordType_t WORD_CRED = 2'b00;
    localparam wordType_t WORD_IDLE = 2'b11;

    // Field positions inside a 16-bit link word
    localparam int TYPE_HI   = 15;
    localparam int TYPE_LO   = 14;
    localparam int HEAD_BITS = 13;   // word[12:0] -> flit[20:8]
    localparam int TAIL_BITS = 8;    // word[7:0]  -> flit[7:0]
    localparam int CRED_BITS = 2;    // word[1:0]  -> nonFullVCs

    // Framing FSM states
    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_TAIL = 1'b1;

    // Extract the word type of a link word
    function automatic wordType_t wordTypeOf(input logic [15:0] word);
        return word[TYPE_HI:TYPE_LO];
    endfunction

endpackage

// File: rtl/flit_vc_fifo.sv
// ---------------------------------------------------------------------------
// flit_vc_fifo
// Single virtual-channel flit buffer, DEPTH entries (power of two, >= 2).
// A push into a full FIFO is ignored unless a pop happens in the same cycle,
// so stored flits are never overwritten.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, pushData    enqueue request and flit
//   pop               dequeue request (ignored when empty)
//   headData          flit at the head of the queue (valid when !empty)
//   count             current occupancy, 0..DEPTH
//   full, empty       occupancy flags
// ---------------------------------------------------------------------------
module flit_vc_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           headData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign doPop    = pop && !empty;
    // A full FIFO can still accept when the head leaves in the same cycle
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    // Storage array carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count <= count + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/aurora_flit_rx_unpack.sv
// ---------------------------------------------------------------------------
// aurora_flit_rx_unpack
// Receive side of an Aurora-bridged CONNECT link. Decodes 16-bit Aurora words
// into 21-bit flits (head word + tail word) and credit updates, buffers flits
// per VC and serves them round-robin to the local router.
// Ports:
//   CLK, RST_N                  Aurora USER_CLK, asynchronous active-low reset
//   CHANNEL_UP                  link up; low resets framing and remote credits
//   RX_D, RX_SRC_RDY_N          Aurora RX word and active-low valid
//   EN_getFlit, getFlit         router dequeue strobe and presented flit
//   putNonFullVCs_nonFullVCs,
//   EN_putNonFullVCs            downstream router's non-full VCs and latch strobe
//   remoteNonFullVCs            last credit word received from the link
//   localNonFullVCs             per-VC "buffer not full", sent back by local TX
//   rx_err                      sticky drop / framing error flag
// Optional build macro AURORA_RX_STATS_EN adds saturating 16-bit counters
//   stat_flits, stat_drops, stat_frame_errs.
// ---------------------------------------------------------------------------
module aurora_flit_rx_unpack
    import aurora_link_pkg::*;
#(
    parameter int FLIT_W  = 21,
    parameter int NUM_VCS = 2,
    parameter int VC_LSB  = 0,
    parameter int DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CHANNEL_UP,
    input  logic [15:0]        RX_D,
    input  logic               RX_SRC_RDY_N,
    input  logic               EN_getFlit,
    output logic [FLIT_W-1:0]  getFlit,
    input  logic [NUM_VCS-1:0] putNonFullVCs_nonFullVCs,
    input  logic               EN_putNonFullVCs,
    output logic [NUM_VCS-1:0] remoteNonFullVCs,
    output logic [NUM_VCS-1:0] localNonFullVCs,
    output logic               rx_err
`ifdef AURORA_RX_STATS_EN
    ,
    output logic [15:0]        stat_flits,
    output logic [15:0]        stat_drops,
    output logic [15:0]        stat_frame_errs
`endif
);

    localparam int VC_W  = $clog2(NUM_VCS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [0:0]           state;
    logic [HEAD_BITS-1:0] partialFlit;
    logic [NUM_VCS-1:0]   downNonFull;
    logic [VC_W-1:0]      rrPtr;

    logic                 wordValid;
    logic                 isHead;
    logic                 isTail;
    logic                 isCred;
    logic                 frameErr;
    logic [FLIT_W-1:0]    assembled;
    logic                 enqReq;
    logic [VC_W-1:0]      enqVc;
    logic                 drop;
    logic                 unusedRxBit;

    logic [FLIT_W-1:0]    fifoHead  [NUM_VCS];
    logic [CNT_W-1:0]     fifoCount [NUM_VCS];
    logic [NUM_VCS-1:0]   push;
    logic [NUM_VCS-1:0]   pop;
    logic [NUM_VCS-1:0]   full;
    logic [NUM_VCS-1:0]   empty;
    logic [NUM_VCS-1:0]   eligible;

    logic [VC_W-1:0]      sel;
    logic                 selValid;
    logic                 deq;

    // Word decode; nothing from the link is acted on while the channel is down
    assign wordValid   = CHANNEL_UP && !RX_SRC_RDY_N;
    assign isHead      = wordValid && (wordTypeOf(RX_D) == WORD_HEAD);
    assign isTail      = wordValid && (wordTypeOf(RX_D) == WORD_TAIL);
    assign isCred      = wordValid && (wordTypeOf(RX_D) == WORD_CRED);
    assign unusedRxBit = RX_D[13];

    assign frameErr  = (isTail && state == ST_IDLE) || (isHead && state == ST_WAIT_TAIL);
    assign assembled = {partialFlit, RX_D[TAIL_BITS-1:0]};
    assign enqVc     = assembled[VC_LSB +: VC_W];
    // A flit whose valid bit is clear is dropped silently, without rx_err
    assign enqReq    = isTail && (state == ST_WAIT_TAIL) && assembled[FLIT_W-1];

    // One FIFO per VC; drops happen only when full with no same-cycle pop
    for (genvar g = 0; g < NUM_VCS; g++) begin : gVc
        assign push[g]            = enqReq && (enqVc == VC_W'(g));
        assign pop[g]             = deq && (sel == VC_W'(g));
        assign eligible[g]        = !empty[g] && downNonFull[g];
        assign localNonFullVCs[g] = (fifoCount[g] != CNT_W'(DEPTH));

        flit_vc_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (DEPTH)
        ) uFifo (
            .clk      (CLK),
            .rst_n    (RST_N),
            .push     (push[g]),
            .pushData (assembled),
            .pop      (pop[g]),
            .headData (fifoHead[g]),
            .count    (fifoCount[g]),
            .full     (full[g]),
            .empty    (empty[g])
        );
    end

    assign drop = |(push & full & ~pop);

    // Round-robin pick: scan from rrPtr upward, walking backwards so the
    // eligible VC closest to the pointer is the one that sticks
    always_comb begin
        int idx;
        idx      = 0;
        sel      = '0;
        selValid = 1'b0;
        for (int i = NUM_VCS - 1; i >= 0; i--) begin
            idx = (int'(rrPtr) + i) % NUM_VCS;
            if (eligible[idx[VC_W-1:0]]) begin
                sel      = idx[VC_W-1:0];
                selValid = 1'b1;
            end
        end
    end

    assign getFlit = selValid ? fifoHead[sel] : '0;
    assign deq     = EN_getFlit && selValid;

    // Framing FSM, credit capture, downstream latch, arbitration pointer, error flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state            <= ST_IDLE;
            partialFlit      <= '0;
            remoteNonFullVCs <= '0;
            downNonFull      <= '1;
            rrPtr            <= '0;
            rx_err           <= 1'b0;
        end else begin
            if (EN_putNonFullVCs) begin
                downNonFull <= putNonFullVCs_nonFullVCs;
            end
            if (deq) begin
                rrPtr <= (sel == VC_W'(NUM_VCS - 1)) ? '0 : sel + VC_W'(1);
            end
            if (frameErr || drop) begin
                rx_err <= 1'b1;
            end
            if (!CHANNEL_UP) begin
                state            <= ST_IDLE;
                partialFlit      <= '0;
                remoteNonFullVCs <= '0;
            end else begin
                if (isCred) begin
                    remoteNonFullVCs <= RX_D[NUM_VCS-1:0];
                end
                case (state)
                    ST_IDLE: begin
                        if (isHead) begin
                            partialFlit <= RX_D[HEAD_BITS-1:0];
                            state       <= ST_WAIT_TAIL;
                        end
                    end
                    default: begin
                        if (isHead) begin
                            partialFlit <= RX_D[HEAD_BITS-1:0];
                        end else if (isTail) begin
                            state <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

`ifdef AURORA_RX_STATS_EN
    // Saturating event counters; they hold at all-ones rather than wrapping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_flits      <= '0;
            stat_drops      <= '0;
            stat_frame_errs <= '0;
        end else begin
            if (enqReq && !drop && stat_flits != 16'hFFFF) begin
                stat_flits <= stat_flits + 16'd1;
            end
            if (drop && stat_drops != 16'hFFFF) begin
                stat_drops <= stat_drops + 16'd1;
            end
            if (frameErr && stat_frame_errs != 16'hFFFF) begin
                stat_frame_errs <= stat_frame_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aurora_flit_rx_unpack.sv
// ---------------------------------------------------------------------------
// tb_aurora_flit_rx_unpack
// Directed self-checking bench for aurora_flit_rx_unpack. Inputs change on the
// falling edge; outputs are inspected on the falling edge after the rising
// edge that consumed the stimulus.
// ---------------------------------------------------------------------------
module tb_aurora_flit_rx_unpack;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CHANNEL_UP;
    logic [15:0] RX_D;
    logic        RX_SRC_RDY_N;
    logic        EN_getFlit;
    logic [20:0] getFlit;
    logic [1:0]  putNonFullVCs_nonFullVCs;
    logic        EN_putNonFullVCs;
    logic [1:0]  remoteNonFullVCs;
    logic [1:0]  localNonFullVCs;
    logic        rx_err;
`ifdef AURORA_RX_STATS_EN
    logic [15:0] stat_flits;
    logic [15:0] stat_drops;
    logic [15:0] stat_frame_errs;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    aurora_flit_rx_unpack dut (
        .CLK                      (CLK),
        .RST_N                    (RST_N),
        .CHANNEL_UP               (CHANNEL_UP),
        .RX_D                     (RX_D),
        .RX_SRC_RDY_N             (RX_SRC_RDY_N),
        .EN_getFlit               (EN_getFlit),
        .getFlit                  (getFlit),
        .putNonFullVCs_nonFullVCs (putNonFullVCs_nonFullVCs),
        .EN_putNonFullVCs         (EN_putNonFullVCs),
        .remoteNonFullVCs         (remoteNonFullVCs),
        .localNonFullVCs          (localNonFullVCs),
        .rx_err                   (rx_err)
`ifdef AURORA_RX_STATS_EN
        ,
        .stat_flits               (stat_flits),
        .stat_drops               (stat_drops),
        .stat_frame_errs          (stat_frame_errs)
`endif
    );

    // Apply reset with all inputs quiet, release on a falling edge
    task automatic doReset();
        RST_N                    = 1'b0;
        CHANNEL_UP               = 1'b1;
        RX_D                     = 16'hFFFF;
        RX_SRC_RDY_N             = 1'b1;
        EN_getFlit               = 1'b0;
        putNonFullVCs_nonFullVCs = 2'b11;
        EN_putNonFullVCs         = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic sendWord(input logic [15:0] w);
        @(negedge CLK);
        RX_D         = w;
        RX_SRC_RDY_N = 1'b0;
    endtask

    task automatic idleCycle();
        @(negedge CLK);
        RX_D         = 16'hFFFF;
        RX_SRC_RDY_N = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL reset_getFlit got=%h exp=%h", getFlit, 21'h0); end
        total++; if (remoteNonFullVCs !== 2'b00) begin bad++; $display("[TB] FAIL reset_remote got=%b exp=00", remoteNonFullVCs); end
        total++; if (localNonFullVCs !== 2'b11) begin bad++; $display("[TB] FAIL reset_local got=%b exp=11", localNonFullVCs); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", rx_err); end
    endtask

    task automatic test_basic_flit();
        doReset();
        sendWord(16'h9ABC);
        sendWord(16'h4055);
        idleCycle();
        total++; if (getFlit !== 21'h1ABC55) begin bad++; $display("[TB] FAIL basic_flit got=%h exp=%h", getFlit, 21'h1ABC55); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_err got=%b exp=0", rx_err); end
        EN_getFlit = 1'b1;
        @(negedge CLK);
        EN_getFlit = 1'b0;
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL basic_drain got=%h exp=%h", getFlit, 21'h0); end
    endtask

    task automatic test_fill_drop();
        logic [20:0] exp;
        doReset();
        for (int k = 0; k < 4; k++) begin
            sendWord(16'h9000 + 16'(k));
            sendWord(16'h4000 + 16'(2 * k));
        end
        idleCycle();
        total++; if (localNonFullVCs !== 2'b10) begin bad++; $display("[TB] FAIL fill_local4 got=%b exp=10", localNonFullVCs); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL fill_err4 got=%b exp=0", rx_err); end
        sendWord(16'h9004);
        sendWord(16'h4008);
        idleCycle();
        total++; if (rx_err !== 1'b1) begin bad++; $display("[TB] FAIL fill_drop_err got=%b exp=1", rx_err); end
        for (int k = 0; k < 4; k++) begin
            exp = {13'h1000 + 13'(k), 8'(2 * k)};
            total++; if (getFlit !== exp) begin bad++; $display("[TB] FAIL fill_drain%0d got=%h exp=%h", k, getFlit, exp); end
            EN_getFlit = 1'b1;
            @(negedge CLK);
        end
        EN_getFlit = 1'b0;
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL fill_only4 got=%h exp=%h", getFlit, 21'h0); end
        total++; if (localNonFullVCs !== 2'b11) begin bad++; $display("[TB] FAIL fill_local_empty got=%b exp=11", localNonFullVCs); end
    endtask

    task automatic test_framing();
        doReset();
        sendWord(16'h4055);
        idleCycle();
        total++; if (rx_err !== 1'b1) begin bad++; $display("[TB] FAIL frame_tail_err got=%b exp=1", rx_err); end
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL frame_tail_drop got=%h exp=%h", getFlit, 21'h0); end
        sendWord(16'h9111);
        sendWord(16'h9222);
        sendWord(16'h4044);
        idleCycle();
        total++; if (getFlit !== 21'h122244) begin bad++; $display("[TB] FAIL frame_second_head got=%h exp=%h", getFlit, 21'h122244); end
        EN_getFlit = 1'b1;
        @(negedge CLK);
        EN_getFlit = 1'b0;
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL frame_one_flit got=%h exp=%h", getFlit, 21'h0); end
    endtask

    task automatic test_credit();
        doReset();
        sendWord(16'h9ABC);
        sendWord(16'h0002);
        @(negedge CLK);
        total++; if (remoteNonFullVCs !== 2'b10) begin bad++; $display("[TB] FAIL credit_remote got=%b exp=10", remoteNonFullVCs); end
        RX_D         = 16'h4054;
        RX_SRC_RDY_N = 1'b0;
        idleCycle();
        total++; if (getFlit !== 21'h1ABC54) begin bad++; $display("[TB] FAIL credit_flit got=%h exp=%h", getFlit, 21'h1ABC54); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL credit_err got=%b exp=0", rx_err); end
    endtask

    task automatic test_round_robin();
        doReset();
        sendWord(16'h9001); sendWord(16'h40A0);
        sendWord(16'h9003); sendWord(16'h40B1);
        sendWord(16'h9002); sendWord(16'h40A2);
        sendWord(16'h9004); sendWord(16'h40B3);
        idleCycle();
        EN_getFlit = 1'b1;
        total++; if (getFlit !== 21'h1001A0) begin bad++; $display("[TB] FAIL rr_first got=%h exp=%h", getFlit, 21'h1001A0); end
        @(negedge CLK);
        total++; if (getFlit !== 21'h1003B1) begin bad++; $display("[TB] FAIL rr_second got=%h exp=%h", getFlit, 21'h1003B1); end
        @(negedge CLK);
        total++; if (getFlit !== 21'h1002A2) begin bad++; $display("[TB] FAIL rr_third got=%h exp=%h", getFlit, 21'h1002A2); end
        @(negedge CLK);
        EN_getFlit = 1'b0;
        total++; if (getFlit !== 21'h1004B3) begin bad++; $display("[TB] FAIL rr_vc1_left got=%h exp=%h", getFlit, 21'h1004B3); end
        putNonFullVCs_nonFullVCs = 2'b01;
        EN_putNonFullVCs         = 1'b1;
        @(negedge CLK);
        EN_putNonFullVCs = 1'b0;
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL rr_vc1_blocked got=%h exp=%h", getFlit, 21'h0); end
        sendWord(16'h9005); sendWord(16'h40C4);
        idleCycle();
        total++; if (getFlit !== 21'h1005C4) begin bad++; $display("[TB] FAIL rr_vc0_only got=%h exp=%h", getFlit, 21'h1005C4); end
        EN_getFlit = 1'b1;
        @(negedge CLK);
        EN_getFlit = 1'b0;
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL rr_vc0_drained got=%h exp=%h", getFlit, 21'h0); end
        putNonFullVCs_nonFullVCs = 2'b11;
        EN_putNonFullVCs         = 1'b1;
        @(negedge CLK);
        EN_putNonFullVCs = 1'b0;
        total++; if (getFlit !== 21'h1004B3) begin bad++; $display("[TB] FAIL rr_vc1_reopen got=%h exp=%h", getFlit, 21'h1004B3); end
    endtask

    task automatic test_channel_down();
        doReset();
        sendWord(16'h9444); sendWord(16'h4022);
        sendWord(16'h0003);
        sendWord(16'h9ABC);
        @(negedge CLK);
        RX_D         = 16'hFFFF;
        RX_SRC_RDY_N = 1'b1;
        total++; if (remoteNonFullVCs !== 2'b11) begin bad++; $display("[TB] FAIL chdown_remote_pre got=%b exp=11", remoteNonFullVCs); end
        CHANNEL_UP = 1'b0;
        @(negedge CLK);
        CHANNEL_UP = 1'b1;
        total++; if (remoteNonFullVCs !== 2'b00) begin bad++; $display("[TB] FAIL chdown_remote got=%b exp=00", remoteNonFullVCs); end
        total++; if (getFlit !== 21'h144422) begin bad++; $display("[TB] FAIL chdown_retain got=%h exp=%h", getFlit, 21'h144422); end
        sendWord(16'h9333); sendWord(16'h4011);
        idleCycle();
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL chdown_err got=%b exp=0", rx_err); end
        EN_getFlit = 1'b1;
        @(negedge CLK);
        EN_getFlit = 1'b0;
        total++; if (getFlit !== 21'h133311) begin bad++; $display("[TB] FAIL chdown_relink got=%h exp=%h", getFlit, 21'h133311); end
    endtask

    task automatic test_async_reset();
        doReset();
        sendWord(16'h0001);
        sendWord(16'h9777); sendWord(16'h4066);
        sendWord(16'h4066);
        idleCycle();
        total++; if (rx_err !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre_err got=%b exp=1", rx_err); end
        #2;
        RST_N = 1'b0;
        #1;
        total++; if (getFlit !== 21'h0) begin bad++; $display("[TB] FAIL areset_getFlit got=%h exp=%h", getFlit, 21'h0); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL areset_err got=%b exp=0", rx_err); end
        total++; if (remoteNonFullVCs !== 2'b00) begin bad++; $display("[TB] FAIL areset_remote got=%b exp=00", remoteNonFullVCs); end
        total++; if (localNonFullVCs !== 2'b11) begin bad++; $display("[TB] FAIL areset_local got=%b exp=11", localNonFullVCs); end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_flit();
        test_fill_drop();
        test_framing();
        test_credit();
        test_round_robin();
        test_channel_down();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
